// File: rtl/vga_pkg.sv
// Shared game constants: key codes, PS/2 scancodes, FSM encodings.
// Also holds the scancode-to-key mapping helpers.
package vga_pkg;

  localparam logic [3:0] key_NONE  = 4'h0;
  localparam logic [3:0] key_A     = 4'h1;
  localparam logic [3:0] key_D     = 4'h2;
  localparam logic [3:0] key_W     = 4'h3;
  localparam logic [3:0] key_S     = 4'h4;
  localparam logic [3:0] key_E     = 4'h5;
  localparam logic [3:0] key_SPACE = 4'h6;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    D_BASE,
    D_EXT,
    D_BRK,
    D_EXT_BRK
  } dec_state_t;

  function automatic logic [3:0] map_code(
    input logic       ext,
    input logic [7:0] sc
  );
    map_code = key_NONE;
    if (!ext) begin
      case (sc)
        8'h1C:   map_code = key_A;
        8'h23:   map_code = key_D;
        8'h1D:   map_code = key_W;
        8'h1B:   map_code = key_S;
        8'h24:   map_code = key_E;
        8'h29:   map_code = key_SPACE;
        default: map_code = key_NONE;
      endcase
    end else begin
      case (sc)
        8'h6B:   map_code = key_A;
        8'h74:   map_code = key_D;
        8'h75:   map_code = key_W;
        8'h72:   map_code = key_S;
        default: map_code = key_NONE;
      endcase
    end
  endfunction

  // Mask bit i holds key code i+1.
  function automatic logic [5:0] key_bit(input logic [3:0] k);
    case (k)
      key_A:     key_bit = 6'b000001;
      key_D:     key_bit = 6'b000010;
      key_W:     key_bit = 6'b000100;
      key_S:     key_bit = 6'b001000;
      key_E:     key_bit = 6'b010000;
      key_SPACE: key_bit = 6'b100000;
      default:   key_bit = 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/keyboard_decoder_ps2_rx.sv
// PS/2 receiver: pin sync, run-length filter, frame FSM, idle timeout.
// Emits each good byte with a one-cycle valid, bad frames with frame_err.
module ps2_rx
  import vga_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 130000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_filt_q, dat_filt_q, clk_prev_q;
  logic [FW-1:0] clk_cnt_q, dat_cnt_q;
  logic          strobe;

  // Pins idle high, so the conditioning chain resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
      clk_cnt_q  <= '0;
      dat_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_prev_q <= clk_filt_q;
      if (clk_sync_q[1] == clk_filt_q) begin
        clk_cnt_q <= '0;
      end else if (clk_cnt_q == FILT_MAX) begin
        clk_filt_q <= clk_sync_q[1];
        clk_cnt_q  <= '0;
      end else begin
        clk_cnt_q <= clk_cnt_q + FW'(1);
      end
      if (dat_sync_q[1] == dat_filt_q) begin
        dat_cnt_q <= '0;
      end else if (dat_cnt_q == FILT_MAX) begin
        dat_filt_q <= dat_sync_q[1];
        dat_cnt_q  <= '0;
      end else begin
        dat_cnt_q <= dat_cnt_q + FW'(1);
      end
    end
  end

  assign strobe = clk_prev_q & ~clk_filt_q;

  rx_state_t     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    sc_q, sc_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    sc_d    = sc_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    tmo_d   = (state_q == RX_IDLE || strobe) ? '0 : tmo_q + TW'(1);
    if (strobe) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!dat_filt_q) begin
            state_d = RX_DATA;
            bit_d   = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d = {dat_filt_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = dat_filt_q;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (dat_filt_q && ^{shift_q, par_q}) begin
            valid_d = 1'b1;
            sc_d    = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && tmo_q == TMO_MAX) begin
      // A stalled partial frame is dropped silently.
      state_d = RX_IDLE;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      sc_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      sc_q    <= sc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign scancode       = sc_q;
  assign scancode_valid = valid_q;
  assign frame_err      = err_q;

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard to game key: prefix decoding, held-key mask,
// and a registered key output preferring the most recent make.
module keyboard_decoder
  import vga_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 130000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_err
);

  ps2_rx #(
    .FILT_LEN   (FILT_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .frame_err     (frame_err)
  );

  dec_state_t dst_q, dst_d;
  logic [5:0] mask_q, mask_d;
  logic [3:0] last_q, last_d;
  logic [3:0] key_q, key_d;
  logic       make, brk, ext;
  logic [3:0] code;
  logic [5:0] kb;

  always_comb begin
    dst_d  = dst_q;
    mask_d = mask_q;
    last_d = last_q;
    make   = 1'b0;
    brk    = 1'b0;
    ext    = 1'b0;
    if (frame_err) begin
      dst_d = D_BASE;
    end else if (scancode_valid) begin
      unique case (dst_q)
        D_BASE: begin
          if (scancode == SC_EXT)      dst_d = D_EXT;
          else if (scancode == SC_BRK) dst_d = D_BRK;
          else                         make  = 1'b1;
        end
        D_EXT: begin
          if (scancode == SC_BRK) begin
            dst_d = D_EXT_BRK;
          end else begin
            make  = 1'b1;
            ext   = 1'b1;
            dst_d = D_BASE;
          end
        end
        D_BRK: begin
          brk   = 1'b1;
          dst_d = D_BASE;
        end
        D_EXT_BRK: begin
          brk   = 1'b1;
          ext   = 1'b1;
          dst_d = D_BASE;
        end
        default: dst_d = D_BASE;
      endcase
    end
    code = map_code(ext, scancode);
    kb   = key_bit(code);
    if (make && code != key_NONE) begin
      mask_d = mask_q | kb;
      last_d = code;
    end
    if (brk) mask_d = mask_q & ~kb;
  end

  // Most recent make wins; otherwise the lowest held code.
  always_comb begin
    key_d = key_NONE;
    for (int i = 5; i >= 0; i--) begin
      if (mask_q[i]) key_d = 4'(i + 1);
    end
    if (|(mask_q & key_bit(last_q))) key_d = last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q  <= D_BASE;
      mask_q <= '0;
      last_q <= key_NONE;
      key_q  <= key_NONE;
    end else begin
      dst_q  <= dst_d;
      mask_q <= mask_d;
      last_q <= last_d;
      key_q  <= key_d;
    end
  end

  assign key = key_q;

endmodule

// File: tb/tb_keyboard_decoder.sv
// Bench for keyboard_decoder: PS/2 frame driver, scancode scoreboard,
// and per-scenario key/pulse checks.
module tb_keyboard_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  keyboard_decoder #(
    .FILT_LEN   (FILT),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .key           (key),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .frame_err     (frame_err)
  );

  always @(negedge clk) begin
    if (rst_n && frame_err) n_err++;
    if (rst_n && scancode_valid) begin
      logic [7:0] e;
      n_valid++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected scancode=%02h expected=none", scancode);
      end else begin
        e = exp_q.pop_front();
        if (scancode !== e) begin
          bad++;
          $display("FAIL sb_scancode got=%02h expected=%02h", scancode, e);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip);
    if (!flip) exp_q.push_back(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ flip);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(HALF);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_cyc(4);
    #1;
    total++;
    if (key !== 4'h0) begin
      bad++; $display("FAIL rst_key got=%0h expected=0", key);
    end
    total++;
    if (scancode !== 8'h00) begin
      bad++; $display("FAIL rst_sc got=%02h expected=00", scancode);
    end
    total++;
    if (scancode_valid !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_pulses got=%b%b expected=00",
               scancode_valid, frame_err);
    end
    rst_n = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_make_break;
    int v0 = n_valid;
    send_frame(8'h1C, 1'b0);
    total++;
    if (key !== 4'h1) begin
      bad++; $display("FAIL a_make key=%0h expected=1", key);
    end
    total++;
    if (n_valid - v0 !== 1) begin
      bad++; $display("FAIL a_pulses got=%0d expected=1", n_valid - v0);
    end
    total++;
    if (scancode !== 8'h1C) begin
      bad++; $display("FAIL a_sc got=%02h expected=1c", scancode);
    end
    send_frame(8'hF0, 1'b0);
    total++;
    if (key !== 4'h1) begin
      bad++; $display("FAIL a_f0 key=%0h expected=1", key);
    end
    send_frame(8'h1C, 1'b0);
    total++;
    if (key !== 4'h0) begin
      bad++; $display("FAIL a_break key=%0h expected=0", key);
    end
  endtask

  task automatic test_two_keys;
    send_frame(8'h23, 1'b0);
    total++;
    if (key !== 4'h2) begin
      bad++; $display("FAIL two_d key=%0h expected=2", key);
    end
    send_frame(8'h1C, 1'b0);
    total++;
    if (key !== 4'h1) begin
      bad++; $display("FAIL two_a key=%0h expected=1", key);
    end
    send_frame(8'h1C, 1'b0);
    total++;
    if (key !== 4'h1) begin
      bad++; $display("FAIL two_repeat key=%0h expected=1", key);
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    total++;
    if (key !== 4'h2) begin
      bad++; $display("FAIL two_rel_a key=%0h expected=2", key);
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h23, 1'b0);
    total++;
    if (key !== 4'h0) begin
      bad++; $display("FAIL two_rel_d key=%0h expected=0", key);
    end
  endtask

  task automatic test_extended;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h74, 1'b0);
    total++;
    if (key !== 4'h2) begin
      bad++; $display("FAIL ext_make key=%0h expected=2", key);
    end
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    total++;
    if (key !== 4'h2) begin
      bad++; $display("FAIL ext_f0 key=%0h expected=2", key);
    end
    send_frame(8'h74, 1'b0);
    total++;
    if (key !== 4'h0) begin
      bad++; $display("FAIL ext_break key=%0h expected=0", key);
    end
  endtask

  task automatic test_parity_err;
    int v0, e0;
    send_frame(8'h1C, 1'b0);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h23, 1'b1);
    total++;
    if (n_err - e0 !== 1) begin
      bad++; $display("FAIL par_err got=%0d expected=1", n_err - e0);
    end
    total++;
    if (n_valid - v0 !== 0) begin
      bad++; $display("FAIL par_valid got=%0d expected=0", n_valid - v0);
    end
    total++;
    if (key !== 4'h1) begin
      bad++; $display("FAIL par_key key=%0h expected=1", key);
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    total++;
    if (key !== 4'h0) begin
      bad++; $display("FAIL par_rel key=%0h expected=0", key);
    end
  endtask

  task automatic test_timeout;
    int v0, e0;
    logic [7:0] b = 8'h1D;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    ps2_data = 1'b1;
    wait_cyc(TMO + 10);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h1D, 1'b0);
    total++;
    if (key !== 4'h3) begin
      bad++; $display("FAIL tmo_key key=%0h expected=3", key);
    end
    total++;
    if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
      bad++;
      $display("FAIL tmo_pulses valid=%0d err=%0d expected=1,0",
               n_valid - v0, n_err - e0);
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    total++;
    if (key !== 4'h0) begin
      bad++; $display("FAIL tmo_rel key=%0h expected=0", key);
    end
  endtask

  task automatic test_glitch;
    int v0 = n_valid;
    int e0 = n_err;
    int lens[3] = '{1, 3, FILT - 1};
    ps2_data = 1'b0;
    wait_cyc(5);
    foreach (lens[i]) begin
      ps2_clk = 1'b0;
      wait_cyc(lens[i]);
      ps2_clk = 1'b1;
      wait_cyc(15);
    end
    ps2_data = 1'b1;
    wait_cyc(15);
    send_frame(8'h1B, 1'b0);
    total++;
    if (key !== 4'h4) begin
      bad++; $display("FAIL glitch_key key=%0h expected=4", key);
    end
    total++;
    if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
      bad++;
      $display("FAIL glitch_pulses valid=%0d err=%0d expected=1,0",
               n_valid - v0, n_err - e0);
    end
  endtask

  task automatic test_reset_midframe;
    int v0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (key !== 4'h0) begin
      bad++; $display("FAIL mid_rst_key key=%0h expected=0", key);
    end
    total++;
    if (scancode !== 8'h00) begin
      bad++; $display("FAIL mid_rst_sc got=%02h expected=00", scancode);
    end
    ps2_data = 1'b1;
    ps2_clk = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    v0 = n_valid;
    send_frame(8'h1D, 1'b0);
    total++;
    if (key !== 4'h3) begin
      bad++; $display("FAIL mid_next key=%0h expected=3", key);
    end
    total++;
    if (n_valid - v0 !== 1) begin
      bad++; $display("FAIL mid_pulses got=%0d expected=1", n_valid - v0);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_two_keys();
    test_extended();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    wait_cyc(5);
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
